dm_sba_engine: RTL

DM_SBA_ENGINE -- requirements
Module: dm_sba_engine

---
 rtl/dm_pkg.sv | 35 +++
 rtl/dm_sba_lane_align.sv | 36 +++
 rtl/dm_sba_engine.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared debug-module types: SBA FSM states, sberror codes and the sbcs register layout.
package dm_pkg;

  typedef enum logic [2:0] {
    Idle,
    Read,
    Write,
    WaitRead,
    WaitWrite
  } sba_state_e;

  localparam logic [2:0] SbErrNone  = 3'd0;
  localparam logic [2:0] SbErrBus   = 3'd2;
  localparam logic [2:0] SbErrAlign = 3'd3;
  localparam logic [2:0] SbErrSize  = 3'd4;

  typedef struct packed {
    logic [2:0] sbversion;
    logic [5:0] zero0;
    logic       sbbusyerror;
    logic       sbbusy;
    logic       sbreadonaddr;
    logic [2:0] sbaccess;
    logic       sbautoincrement;
    logic       sbreadondata;
    logic [2:0] sberror;
    logic [6:0] sbasize;
    logic       sbaccess128;
    logic       sbaccess64;
    logic       sbaccess32;
    logic       sbaccess16;
    logic       sbaccess8;
  } sbcs_t;

endpackage

// File: rtl/dm_sba_lane_align.sv
// Byte-lane steering for system bus accesses: byte enables, write replication and
// read shift / zero-extension. Purely combinational.
module dm_sba_lane_align #(
  parameter int unsigned BusWidth = 32
) (
  input  logic [$clog2(BusWidth/8)-1:0] offset_i,
  input  logic [2:0]                    access_i,
  input  logic [BusWidth-1:0]           wdata_i,
  input  logic [BusWidth-1:0]           rdata_i,
  output logic [BusWidth/8-1:0]         be_o,
  output logic [BusWidth-1:0]           wdata_o,
  output logic [BusWidth-1:0]           rdata_o
);

  localparam int unsigned NumBytes = BusWidth / 8;

  logic [BusWidth-1:0] rdata_shifted;

  always_comb begin
    int size;
    size          = 1 << access_i;
    be_o          = '0;
    wdata_o       = '0;
    rdata_o       = '0;
    rdata_shifted = rdata_i >> {offset_i, 3'b000};
    for (int i = 0; i < NumBytes; i++) begin
      be_o[i] = (i >= int'(offset_i)) && (i < int'(offset_i) + size);
      // Each lane carries the data byte at the same position within its access-sized slot.
      wdata_o[8*i +: 8] = wdata_i[8*(i & (size - 1)) +: 8];
      if (i < size) begin
        rdata_o[8*i +: 8] = rdata_shifted[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dm_sba_engine.sv
// System bus access engine for the debug module. Define DM_SBA_ERR_CHECK_EN to report
// oversize/misaligned accesses; otherwise size is clamped and the offset truncated.
module dm_sba_engine
  import dm_pkg::*;
#(
  parameter int unsigned BusWidth       = 32,
  parameter logic        ReadOnAddrDflt = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dmactive_i,
  input  logic [BusWidth-1:0]   sbaddress_i,
  input  logic                  sbaddress_write_valid_i,
  input  logic [BusWidth-1:0]   sbdata_i,
  input  logic                  sbdata_write_valid_i,
  input  logic                  sbdata_read_valid_i,
  input  logic                  sbreadonaddr_i,
  input  logic                  sbreadondata_i,
  input  logic                  sbautoincrement_i,
  input  logic [2:0]            sbaccess_i,
  output logic [BusWidth-1:0]   sbaddress_o,
  output logic [BusWidth-1:0]   sbdata_o,
  output logic                  sbdata_valid_o,
  output logic                  sbbusy_o,
  output logic [2:0]            sberror_o,
  output logic                  sberror_valid_o,
  output logic                  master_req_o,
  output logic                  master_we_o,
  output logic [BusWidth-1:0]   master_add_o,
  output logic [BusWidth-1:0]   master_wdata_o,
  output logic [BusWidth/8-1:0] master_be_o,
  input  logic                  master_gnt_i,
  input  logic                  master_r_valid_i,
  input  logic                  master_r_err_i,
  input  logic [BusWidth-1:0]   master_r_rdata_i
);

  localparam int unsigned NumBytes  = BusWidth / 8;
  localparam int unsigned OffW      = $clog2(NumBytes);
  localparam logic [2:0]  MaxAccess = 3'(OffW);

  sba_state_e          state_q, state_d;
  logic [BusWidth-1:0] sbaddress_q, sbaddress_d;
  logic [BusWidth-1:0] addr_q, addr_d;
  logic [BusWidth-1:0] wdata_q, wdata_d;
  logic [BusWidth-1:0] rdata_q, rdata_d;
  logic [2:0]          access_q, access_d;
  logic [2:0]          err_q, err_d;
  logic                rdata_valid_q, rdata_valid_d;
  logic                err_valid_q, err_valid_d;
  logic                readonaddr_q;

  logic [BusWidth-1:0] trig_addr;
  logic [2:0]          trig_access;
  logic [2:0]          trig_err_code;
  logic                trig_err;
  logic                addr_trig;
  logic [OffW-1:0]     txn_offset;
  logic [NumBytes-1:0] lane_be;
  logic [BusWidth-1:0] lane_wdata;
  logic [BusWidth-1:0] lane_rdata;
  logic [BusWidth-1:0] incr;

  // Keeps only the offset bits at or above the access size.
  function automatic logic [OffW-1:0] align_mask(input logic [2:0] access);
    for (int b = 0; b < OffW; b++) begin
      align_mask[b] = (b >= int'(access));
    end
  endfunction

  assign trig_addr   = sbaddress_write_valid_i ? sbaddress_i : sbaddress_q;
  assign trig_access = (sbaccess_i > MaxAccess) ? MaxAccess : sbaccess_i;
  assign addr_trig   = sbaddress_write_valid_i && readonaddr_q;

`ifdef DM_SBA_ERR_CHECK_EN
  always_comb begin
    trig_err_code = SbErrNone;
    if (sbaccess_i > MaxAccess) begin
      trig_err_code = SbErrSize;
    end else if ((trig_addr[OffW-1:0] & ~align_mask(sbaccess_i)) != '0) begin
      trig_err_code = SbErrAlign;
    end
  end
`else
  assign trig_err_code = SbErrNone;
`endif

  assign trig_err   = (trig_err_code != SbErrNone);
  assign txn_offset = addr_q[OffW-1:0] & align_mask(access_q);
  assign incr       = {{(BusWidth-1){1'b0}}, 1'b1} << access_q;

  dm_sba_lane_align #(
    .BusWidth (BusWidth)
  ) u_lane_align (
    .offset_i (txn_offset),
    .access_i (access_q),
    .wdata_i  (wdata_q),
    .rdata_i  (master_r_rdata_i),
    .be_o     (lane_be),
    .wdata_o  (lane_wdata),
    .rdata_o  (lane_rdata)
  );

  always_comb begin
    state_d       = state_q;
    sbaddress_d   = sbaddress_q;
    addr_d        = addr_q;
    access_d      = access_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    err_d         = err_q;
    err_valid_d   = 1'b0;

    if (sbaddress_write_valid_i) begin
      sbaddress_d = sbaddress_i;
    end

    unique case (state_q)
      Idle: begin
        if (addr_trig || sbdata_write_valid_i || (sbdata_read_valid_i && sbreadondata_i)) begin
          addr_d   = trig_addr;
          access_d = trig_access;
          wdata_d  = sbdata_i;
          if (trig_err) begin
            err_d       = trig_err_code;
            err_valid_d = 1'b1;
          end else if (addr_trig) begin
            state_d = Read;
          end else if (sbdata_write_valid_i) begin
            state_d = Write;
          end else begin
            state_d = Read;
          end
        end
      end
      Read: begin
        if (master_gnt_i) state_d = WaitRead;
      end
      Write: begin
        if (master_gnt_i) state_d = WaitWrite;
      end
      WaitRead, WaitWrite: begin
        if (master_r_valid_i) begin
          state_d = Idle;
          if (master_r_err_i) begin
            err_d       = SbErrBus;
            err_valid_d = 1'b1;
          end else begin
            if (state_q == WaitRead) begin
              rdata_d       = lane_rdata;
              rdata_valid_d = 1'b1;
            end
            // A fresh address write from the debugger takes precedence over the increment.
            if (sbautoincrement_i && !sbaddress_write_valid_i) begin
              sbaddress_d = sbaddress_q + incr;
            end
          end
        end
      end
      default: state_d = Idle;
    endcase

    if (!dmactive_i) begin
      state_d       = Idle;
      sbaddress_d   = '0;
      addr_d        = '0;
      access_d      = '0;
      wdata_d       = '0;
      rdata_d       = '0;
      rdata_valid_d = 1'b0;
      err_d         = SbErrNone;
      err_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= Idle;
      sbaddress_q   <= '0;
      addr_q        <= '0;
      access_q      <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      err_q         <= SbErrNone;
      err_valid_q   <= 1'b0;
      readonaddr_q  <= ReadOnAddrDflt;
    end else begin
      state_q       <= state_d;
      sbaddress_q   <= sbaddress_d;
      addr_q        <= addr_d;
      access_q      <= access_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      err_q         <= err_d;
      err_valid_q   <= err_valid_d;
      readonaddr_q  <= dmactive_i ? sbreadonaddr_i : ReadOnAddrDflt;
    end
  end

  assign master_req_o    = (state_q == Read) || (state_q == Write);
  assign master_we_o     = (state_q == Write);
  assign master_add_o    = master_req_o ? {addr_q[BusWidth-1:OffW], txn_offset} : '0;
  assign master_be_o     = master_req_o ? lane_be : '0;
  assign master_wdata_o  = master_req_o ? lane_wdata : '0;
  assign sbbusy_o        = (state_q != Idle);
  assign sbaddress_o     = sbaddress_q;
  assign sbdata_o        = rdata_q;
  assign sbdata_valid_o  = rdata_valid_q;
  assign sberror_o       = err_q;
  assign sberror_valid_o = err_valid_q;

endmodule
